// File: rtl/test_i10026.sv
// Golden five-input benchmark circuit: three pipeline flops
// feeding one registered output bit, synchronous active-high reset.
module test_i10026 (
    input  logic CK,
    input  logic reset,
    input  logic N0,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic N4,
    output logic output_single
);

    logic s1;
    logic s2;
    logic s3;
    logic q;

    logic s1_nxt;
    logic s2_nxt;
    logic s3_nxt;
    logic q_nxt;

    // Next-state equations, all evaluated on pre-edge flop values
    always_comb begin
        s1_nxt = N0 ^ N1;
        s2_nxt = N2 & ~N3;
        s3_nxt = s1 | N4;
        q_nxt  = (s1 & ~s2) ^ s3;
    end

    // State pipeline; reset wins over all data inputs
    always_ff @(posedge CK) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= s1_nxt;
            s2 <= s2_nxt;
            s3 <= s3_nxt;
            q  <= q_nxt;
        end
    end

    assign output_single = q;

endmodule

// File: tb/tb_test_i10026.sv
// Self-checking bench for test_i10026: directed cases with literal
// expectations plus a history-based reference model checked every edge.
module tb_test_i10026;

    logic CK;
    logic reset;
    logic N0, N1, N2, N3, N4;
    logic output_single;

    int total;
    int bad;

    test_i10026 dut (
        .CK            (CK),
        .reset         (reset),
        .N0            (N0),
        .N1            (N1),
        .N2            (N2),
        .N3            (N3),
        .N4            (N4),
        .output_single (output_single)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Per-edge record of what the inputs meant at that edge
    logic ha[$];
    logic hb[$];
    logic hc[$];
    logic hr[$];
    bit   armed;

    // Output after edge k, from the input history:
    // out(k) = (a(k-1) & ~b(k-1)) ^ (a(k-2) | c(k-1)),
    // where any term captured at a reset edge is zero.
    function automatic logic model_out(int k);
        logic x1, x2, x3, a2;
        if (hr[k]) return 1'b0;
        if (hr[k-1]) return 1'b0;
        x1 = ha[k-1];
        x2 = hb[k-1];
        a2 = hr[k-2] ? 1'b0 : ha[k-2];
        x3 = a2 | hc[k-1];
        return (x1 & ~x2) ^ x3;
    endfunction

    // Compare process: log inputs at each edge, check output 1ns later
    always @(posedge CK) begin
        int k;
        logic want;
        ha.push_back(N0 ^ N1);
        hb.push_back(N2 & ~N3);
        hc.push_back(N4);
        hr.push_back(reset);
        if (reset) armed = 1'b1;
        k = hr.size() - 1;
        #1;
        if (armed) begin
            want = model_out(k);
            total++;
            if (output_single !== want) begin
                bad++;
                $display("FAIL model_cmp edge=%0d got=%b want=%b",
                         k, output_single, want);
            end
        end
    end

    task automatic cyc(input logic rst, input logic [4:0] v);
        @(negedge CK);
        reset = rst;
        {N0, N1, N2, N3, N4} = v;
        @(posedge CK);
        #2;
    endtask

    task automatic chk(input string name, input logic got,
                       input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    // Hold vector v for n edges; exp holds expected outputs MSB first
    task automatic seq(input string name, input logic [4:0] v,
                       input int n, input logic [7:0] exp);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, v);
            chk($sformatf("%s_e%0d", name, i + 1), output_single,
                exp[n-1-i]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        armed = 1'b0;
        reset = 1'b0;
        {N0, N1, N2, N3, N4} = 5'b0;

        // Reset priority with all inputs high
        cyc(1'b1, 5'b11111);
        chk("rst_out", output_single, 1'b0);
        chk("rst_s1", dut.s1, 1'b0);
        chk("rst_s2", dut.s2, 1'b0);
        chk("rst_s3", dut.s3, 1'b0);
        cyc(1'b1, 5'b11111);
        chk("rst_out2", output_single, 1'b0);

        // All-zero hold
        cyc(1'b1, 5'b00000);
        seq("zero", 5'b00000, 5, 8'b00000);

        // N0-only pulse
        cyc(1'b1, 5'b00000);
        seq("n0", 5'b10000, 5, 8'b01000);

        // N4 steady, then mid-run reset
        cyc(1'b1, 5'b00000);
        seq("n4", 5'b00001, 4, 8'b0111);
        cyc(1'b1, 5'b00001);
        chk("mid_rst", output_single, 1'b0);
        seq("post_rst", 5'b00001, 2, 8'b01);

        // s2 masking
        cyc(1'b1, 5'b00000);
        seq("mask", 5'b10100, 4, 8'b0011);

        // Exhaustive sweep, checked by the model
        cyc(1'b1, 5'b00000);
        for (int v = 0; v < 32; v++) cyc(1'b0, v[4:0]);

        // Random traffic with occasional resets and mid-cycle glitches
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0), 5'($urandom));
            {N0, N1, N2, N3, N4} = 5'($urandom);
            reset = $urandom_range(0, 1) == 1;
        end

        @(negedge CK);
        reset = 1'b0;
        @(posedge CK);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
